// File: rtl/stream_merge21.sv
// rtl/stream_merge21.sv - two-channel round-robin stream merger with source tag and per-channel beat counters
module stream_merge21 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sel;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic w_load;
  logic w_gnt0;
  logic w_gnt1;
  logic w_acc0;
  logic w_acc1;

  // Output register can take a beat when empty or being drained this cycle.
  assign w_load = ~r_out_valid | out_ready;

  // Under contention the channel not served last wins; r_last resets to 1 so channel 0 goes first.
  assign w_gnt0 = in0_valid & (~in1_valid | r_last);
  assign w_gnt1 = in1_valid & (~in0_valid | ~r_last);

  assign in0_ready = w_load & w_gnt0 & rst_n;
  assign in1_ready = w_load & w_gnt1 & rst_n;

  assign w_acc0 = in0_valid & in0_ready;
  assign w_acc1 = in1_valid & in1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 1'b0;
      r_last      <= 1'b1;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      if (w_acc0) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in0_data;
        r_out_sel   <= 1'b0;
        r_last      <= 1'b0;
        r_cnt0      <= r_cnt0 + CNT_W'(1);
      end else if (w_acc1) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in1_data;
        r_out_sel   <= 1'b1;
        r_last      <= 1'b1;
        r_cnt1      <= r_cnt1 + CNT_W'(1);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;

endmodule
